// File: rtl/spi_adc_pkg.sv
// spi_adc_pkg: shared types and constants for the MCP3008-style SPI ADC responder.
//   state_t        - responder frame states
//   CMD_BITS       - command bits after the start bit (SGL, D2, D1, D0)
//   NUM_CH         - number of sample channels
//   DATA_W_DEFAULT - default sample width
package spi_adc_pkg;

  localparam int CMD_BITS       = 4;
  localparam int NUM_CH         = 8;
  localparam int DATA_W_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CMD,
    SAMPLE,
    DATA,
    TAIL
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: STAGES-deep synchronizer for one asynchronous input with
// registered single-cycle edge pulses.
//   clk, rst  - system clock, async active-high reset
//   d         - asynchronous input
//   q         - synchronized level
//   rise/fall - one-cycle pulses, one cycle after q changes
// RESET_VAL is the idle level of the input so that reset release does not
// produce a spurious edge.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {STAGES{RESET_VAL}};
      prev <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
      fall <= ~sync[STAGES-1] & prev;
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/spi_adc_responder.sv
// spi_adc_responder: SPI mode-0 target emulating an 8-channel MCP3008-style ADC.
// Decodes start/SGL/D2..D0 from din, then returns a null bit and a DATA_W-bit
// result (MSB first) on dout. Samples come from a host-written register file.
//   clk, rst          - system clock (>= 4x sclk), async active-high reset
//   sclk, cs, din     - SPI from the master (cs active low)
//   dout, dout_oe     - serial data to master and its drive enable
//   smp_wr/ch/data    - sample register file write port
//   conv_valid        - pulse when a result is snapshotted
//   conv_single/ch    - latched command of the last snapshot
//   frame_err         - pulse when cs rises before B0 was driven
// Build option: define SPI_ADC_LSB_REPEAT_EN to repeat B1..B(DATA_W-1)
// LSB-first after B0; otherwise dout stays 0 after B0.
module spi_adc_responder
  import spi_adc_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              din,
  output logic              dout,
  output logic              dout_oe,
  input  logic              smp_wr,
  input  logic [2:0]        smp_ch,
  input  logic [DATA_W-1:0] smp_data,
  output logic              conv_valid,
  output logic              conv_single,
  output logic [2:0]        conv_ch,
  output logic              frame_err
);

  localparam int IDX_W = $clog2(DATA_W);

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] din_sync;
  logic din_q;
  logic unused_sync;

  logic [DATA_W-1:0] smp [NUM_CH];

  state_t              state, state_n;
  logic [IDX_W-1:0]    cnt, cnt_n, bit_idx;
  logic [CMD_BITS-1:0] cmd, cmd_n;
  logic [DATA_W-1:0]   res, res_n, result;
  logic [DATA_W:0]     diff;
  logic [2:0]          p_idx, q_idx, ch_n;
  logic                dout_n, oe_n, valid_n, single_n, err_n;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(cs), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  assign unused_sync = sclk_q ^ cs_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) din_sync <= '0;
    else     din_sync <= {din_sync[SYNC_STAGES-2:0], din};
  end

  // din's synchronizer has no edge stage, so at a rise pulse it already
  // reflects one more clk of the stable high phase; that is harmless.
  assign din_q = din_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) smp[i] <= '0;
    end else if (smp_wr) begin
      smp[smp_ch] <= smp_data;
    end
  end

  // Differential pair: p is the even channel, q the odd one; D0 picks the
  // subtraction order. One extra bit exposes the sign for clamping.
  assign p_idx = {cmd[2], cmd[1], 1'b0};
  assign q_idx = {cmd[2], cmd[1], 1'b1};

  always_comb begin
    diff   = '0;
    result = '0;
    if (cmd[0]) diff = {1'b0, smp[q_idx]} - {1'b0, smp[p_idx]};
    else        diff = {1'b0, smp[p_idx]} - {1'b0, smp[q_idx]};
    if (cmd[CMD_BITS-1])  result = smp[cmd[2:0]];
    else if (diff[DATA_W]) result = '0;
    else                   result = diff[DATA_W-1:0];
  end

  assign bit_idx = IDX_W'(DATA_W - 1) - cnt;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cmd_n    = cmd;
    res_n    = res;
    dout_n   = dout;
    oe_n     = dout_oe;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    single_n = conv_single;
    ch_n     = conv_ch;
    if (cs_rise) begin
      // Deselect aborts from any state; only frames short of B0 are errors.
      state_n = IDLE;
      oe_n    = 1'b0;
      dout_n  = 1'b0;
      if (state inside {WAIT_START, CMD, SAMPLE, DATA}) err_n = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!cs_q) state_n = WAIT_START;
        end
        WAIT_START: begin
          if (sclk_rise && din_q) begin
            state_n = CMD;
            cnt_n   = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            cmd_n = {cmd[CMD_BITS-2:0], din_q};
            if (cnt == IDX_W'(CMD_BITS - 1)) begin
              state_n = SAMPLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + IDX_W'(1);
            end
          end
        end
        SAMPLE: begin
          if (sclk_fall) begin
            res_n    = result;
            valid_n  = 1'b1;
            single_n = cmd[CMD_BITS-1];
            ch_n     = cmd[2:0];
            dout_n   = 1'b0;
            oe_n     = 1'b1;
            cnt_n    = '0;
            state_n  = DATA;
          end
        end
        DATA: begin
          if (sclk_fall) begin
            dout_n = res[bit_idx];
            if (cnt == IDX_W'(DATA_W - 1)) begin
              state_n = TAIL;
              cnt_n   = IDX_W'(1);
            end else begin
              cnt_n = cnt + IDX_W'(1);
            end
          end
        end
        TAIL: begin
          if (sclk_fall) begin
`ifdef SPI_ADC_LSB_REPEAT_EN
            // cnt walks B1 upward; 0 marks the repeat as exhausted.
            if (cnt != '0) begin
              dout_n = res[cnt];
              cnt_n  = (cnt == IDX_W'(DATA_W - 1)) ? '0 : cnt + IDX_W'(1);
            end else begin
              dout_n = 1'b0;
            end
`else
            dout_n = 1'b0;
`endif
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd         <= '0;
      res         <= '0;
      dout        <= 1'b0;
      dout_oe     <= 1'b0;
      conv_valid  <= 1'b0;
      conv_single <= 1'b0;
      conv_ch     <= '0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cmd         <= cmd_n;
      res         <= res_n;
      dout        <= dout_n;
      dout_oe     <= oe_n;
      conv_valid  <= valid_n;
      conv_single <= single_n;
      conv_ch     <= ch_n;
      frame_err   <= err_n;
    end
  end

endmodule
